cp0_unit: RTL and testbench

Parametrised MIPS coprocessor-0 register block for the AXI pipeline core. It holds BadVAddr, Count, Compare, Status, Cause and EPC, and records exceptions and ERET from the memory stage. It samples external hardware interrupts and, optionally, runs a Count/Compare timer interrupt. It produces the masked interrupt request consumed by the exception unit.

---
 rtl/cp0_pkg.sv | 32 +++
 rtl/cp0_timer.sv | 77 +++++++
 rtl/cp0_unit.sv | 140 ++++++++++++++
 tb/tb_cp0_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field positions and reset values.
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_BEV   = 22;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_BD     = 31;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  // Software-writable Status bits: IM[15:8], EXL, IE.
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count register with clock divider; Compare and the TI flag exist only when CP0_TIMER_INT_EN is defined.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtc0_en,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0] div_reg;
  logic [31:0]      count_reg;
  logic [31:0]      count_next;
  logic             tick;
  logic             count_we;

  assign count_we = mtc0_en && (mtc0_addr == CP0_COUNT);
  assign tick     = (div_reg == DIV_LAST);

  // A software write to Count overrides a coincident divider tick.
  always_comb begin
    count_next = count_reg;
    if (count_we)
      count_next = mtc0_data;
    else if (tick)
      count_next = count_reg + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg   <= '0;
      count_reg <= '0;
    end else begin
      div_reg   <= tick ? '0 : div_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

`ifdef CP0_TIMER_INT_EN
  logic [31:0] compare_reg;
  logic        ti_reg;
  logic        compare_we;

  assign compare_we = mtc0_en && (mtc0_addr == CP0_COMPARE);

  // TI latches only when Count actually changes onto the Compare value.
  always_ff @(posedge clk) begin
    if (rst) begin
      compare_reg <= '0;
      ti_reg      <= 1'b0;
    end else if (compare_we) begin
      compare_reg <= mtc0_data;
      ti_reg      <= 1'b0;
    end else if ((count_we || tick) && (count_next == compare_reg)) begin
      ti_reg      <= 1'b1;
    end
  end

  assign compare = compare_reg;
  assign ti      = ti_reg;
`else
  assign compare = '0;
  assign ti      = 1'b0;
`endif

endmodule

// File: rtl/cp0_unit.sv
// MIPS CP0 register block: exception/ERET capture, interrupt sampling and masked int_req.
// Optional Count/Compare timer interrupt enabled by defining CP0_TIMER_INT_EN.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter int HW_INT_NUM = 6,
  parameter int COUNT_DIV  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HW_INT_NUM-1:0] hw_int,
  input  logic                  exc_valid,
  input  logic                  exc_eret,
  input  logic [4:0]            exc_code,
  input  logic                  exc_in_ds,
  input  logic [31:0]           exc_pc,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  mtc0_en,
  input  logic [4:0]            mtc0_addr,
  input  logic [31:0]           mtc0_data,
  input  logic [4:0]            mfc0_addr,
  output logic [31:0]           mfc0_data,
  output logic [31:0]           epc,
  output logic [31:0]           status,
  output logic [31:0]           cause,
  output logic                  int_req
);

  logic [31:0]           badvaddr_reg;
  logic [31:0]           status_reg;
  logic [31:0]           epc_reg;
  logic [4:0]            exc_code_reg;
  logic                  bd_reg;
  logic [1:0]            sw_ip_reg;
  logic [HW_INT_NUM-1:0] hw_ip_reg;
  logic [31:0]           count;
  logic [31:0]           compare;
  logic                  ti;
  logic [7:0]            ip;
  logic                  exc_take;
  logic                  eret_take;
  logic                  wr_status;
  logic                  wr_cause;
  logic                  wr_epc;

  assign exc_take  = exc_valid && !exc_eret;
  assign eret_take = exc_valid && exc_eret;
  assign wr_status = mtc0_en && (mtc0_addr == CP0_STATUS);
  assign wr_cause  = mtc0_en && (mtc0_addr == CP0_CAUSE);
  assign wr_epc    = mtc0_en && (mtc0_addr == CP0_EPC);

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .mtc0_en   (mtc0_en),
    .mtc0_addr (mtc0_addr),
    .mtc0_data (mtc0_data),
    .count     (count),
    .compare   (compare),
    .ti        (ti)
  );

  // MTC0 is applied first; exception/ERET assignments later in the block override the fields they own.
  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_reg <= '0;
      status_reg   <= STATUS_RESET;
      epc_reg      <= '0;
      exc_code_reg <= '0;
      bd_reg       <= 1'b0;
      sw_ip_reg    <= '0;
      hw_ip_reg    <= '0;
    end else begin
      hw_ip_reg <= hw_int;
      if (wr_status)
        status_reg <= (status_reg & ~STATUS_WMASK) | (mtc0_data & STATUS_WMASK);
      if (wr_cause)
        sw_ip_reg <= mtc0_data[CAUSE_IP_LO+1:CAUSE_IP_LO];
      if (wr_epc)
        epc_reg <= mtc0_data;

      if (exc_take) begin
        status_reg[STATUS_EXL] <= 1'b1;
        exc_code_reg           <= exc_code;
        if (!status_reg[STATUS_EXL]) begin
          epc_reg <= exc_in_ds ? (exc_pc - 32'd4) : exc_pc;
          bd_reg  <= exc_in_ds;
        end
        if (is_addr_exc(exc_code))
          badvaddr_reg <= exc_badvaddr;
      end else if (eret_take) begin
        status_reg[STATUS_EXL] <= 1'b0;
      end
    end
  end

  // Interrupt-pending vector: IP1..0 software, IP2.. hardware, IP7 shared with the timer.
  assign ip[1:0] = sw_ip_reg;

  for (genvar gi = 2; gi < 8; gi++) begin : g_ip
    if (gi == 7) begin : g_ip7
`ifdef CP0_TIMER_INT_EN
      assign ip[gi] = ti;
`else
      if (HW_INT_NUM > 5) begin : g_hw
        assign ip[gi] = hw_ip_reg[gi-2];
      end else begin : g_none
        assign ip[gi] = 1'b0;
      end
`endif
    end else if ((gi - 2) < HW_INT_NUM) begin : g_hw
      assign ip[gi] = hw_ip_reg[gi-2];
    end else begin : g_none
      assign ip[gi] = 1'b0;
    end
  end

  assign status = status_reg;
  assign epc    = epc_reg;
  assign cause  = {bd_reg, ti, 14'b0, ip, 1'b0, exc_code_reg, 2'b00};

  assign int_req = (|(ip & status_reg[STATUS_IM_LO+7:STATUS_IM_LO]))
                   && status_reg[STATUS_IE] && !status_reg[STATUS_EXL];

  always_comb begin
    mfc0_data = '0;
    case (mfc0_addr)
      CP0_BADVADDR: mfc0_data = badvaddr_reg;
      CP0_COUNT:    mfc0_data = count;
      CP0_COMPARE:  mfc0_data = compare;
      CP0_STATUS:   mfc0_data = status;
      CP0_CAUSE:    mfc0_data = cause;
      CP0_EPC:      mfc0_data = epc_reg;
      default:      mfc0_data = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed, table-driven bench for cp0_unit plus hand-written Count and timer sequences.
module tb_cp0_unit;

`ifdef CP0_TIMER_INT_EN
  localparam int HWN = 5;
`else
  localparam int HWN = 6;
`endif

  logic           clk;
  logic           rst;
  logic [HWN-1:0] hw_int;
  logic           exc_valid;
  logic           exc_eret;
  logic [4:0]     exc_code;
  logic           exc_in_ds;
  logic [31:0]    exc_pc;
  logic [31:0]    exc_badvaddr;
  logic           mtc0_en;
  logic [4:0]     mtc0_addr;
  logic [31:0]    mtc0_data;
  logic [4:0]     mfc0_addr;
  logic [31:0]    mfc0_data;
  logic [31:0]    epc;
  logic [31:0]    status;
  logic [31:0]    cause;
  logic           int_req;

  cp0_unit #(
    .HW_INT_NUM (HWN),
    .COUNT_DIV  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hw_int       (hw_int),
    .exc_valid    (exc_valid),
    .exc_eret     (exc_eret),
    .exc_code     (exc_code),
    .exc_in_ds    (exc_in_ds),
    .exc_pc       (exc_pc),
    .exc_badvaddr (exc_badvaddr),
    .mtc0_en      (mtc0_en),
    .mtc0_addr    (mtc0_addr),
    .mtc0_data    (mtc0_data),
    .mfc0_addr    (mfc0_addr),
    .mfc0_data    (mfc0_data),
    .epc          (epc),
    .status       (status),
    .cause        (cause),
    .int_req      (int_req)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "timeout");
  end

  // Expected values describe the state seen during the row's cycle, before its clock edge.
  typedef struct {
    string       name;
    logic        rst;
    logic [5:0]  hw;
    logic        ev;
    logic        er;
    logic [4:0]  code;
    logic        ds;
    logic [31:0] pc;
    logic [31:0] bva;
    logic        men;
    logic [4:0]  maddr;
    logic [31:0] mdata;
    logic [4:0]  raddr;
    logic [31:0] e_mfc0;
    logic [31:0] e_status;
    logic [31:0] e_cause;
    logic [31:0] e_epc;
    logic        e_int;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic add(input string name, input logic r, input logic [5:0] hw,
                     input logic ev, input logic er, input logic [4:0] code, input logic ds,
                     input logic [31:0] pc, input logic [31:0] bva,
                     input logic men, input logic [4:0] maddr, input logic [31:0] mdata,
                     input logic [4:0] raddr, input logic [31:0] e_mfc0,
                     input logic [31:0] e_status, input logic [31:0] e_cause,
                     input logic [31:0] e_epc, input logic e_int);
    vec_t v;
    v.name = name; v.rst = r; v.hw = hw; v.ev = ev; v.er = er; v.code = code; v.ds = ds;
    v.pc = pc; v.bva = bva; v.men = men; v.maddr = maddr; v.mdata = mdata; v.raddr = raddr;
    v.e_mfc0 = e_mfc0; v.e_status = e_status; v.e_cause = e_cause; v.e_epc = e_epc;
    v.e_int = e_int;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    hw_int = '0; exc_valid = 0; exc_eret = 0; exc_code = '0; exc_in_ds = 0;
    exc_pc = '0; exc_badvaddr = '0; mtc0_en = 0; mtc0_addr = '0; mtc0_data = '0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_en = 1; mtc0_addr = a; mtc0_data = d;
    @(negedge clk);
    mtc0_en = 0;
  endtask

  initial begin
    logic [5:0] hw_v;
    logic       seen;
    rst = 1'b1;
    mfc0_addr = 5'd9;
    idle_inputs();

    //   name              rst hw ev er code  ds pc            bva           men addr   data          rd     mfc0          status        cause         epc           int
    add("reset",            1, 0, 0, 0, 5'h0, 0, 32'h0,        32'h0,        0, 5'd0,  32'h0,        5'd9,  32'h0,        32'h0040_0000,32'h0,        32'h0,        0);
    add("exc_adel_ds",      0, 0, 1, 0, 5'h4, 1, 32'hBFC0_0104,32'h1,        0, 5'd0,  32'h0,        5'd8,  32'h0,        32'h0040_0000,32'h0,        32'h0,        0);
    add("exc_nested",       0, 0, 1, 0, 5'h0, 0, 32'h8000_0000,32'hDEAD,     0, 5'd0,  32'h0,        5'd8,  32'h1,        32'h0040_0002,32'h8000_0010,32'hBFC0_0100,0);
    add("eret",             0, 0, 1, 1, 5'h0, 0, 32'h0,        32'h0,        0, 5'd0,  32'h0,        5'd14, 32'hBFC0_0100,32'h0040_0002,32'h8000_0000,32'hBFC0_0100,0);
    add("mtc0_status",      0, 0, 0, 0, 5'h0, 0, 32'h0,        32'h0,        1, 5'd12, 32'h0000_0401, 5'd12, 32'h0040_0000,32'h0040_0000,32'h8000_0000,32'hBFC0_0100,0);
    add("hw_int_assert",    0, 1, 0, 0, 5'h0, 0, 32'h0,        32'h0,        0, 5'd0,  32'h0,        5'd12, 32'h0040_0401,32'h0040_0401,32'h8000_0000,32'hBFC0_0100,0);
    add("hw_int_seen",      0, 1, 0, 0, 5'h0, 0, 32'h0,        32'h0,        0, 5'd0,  32'h0,        5'd13, 32'h8000_0400,32'h0040_0401,32'h8000_0400,32'hBFC0_0100,1);
    add("set_exl",          0, 1, 0, 0, 5'h0, 0, 32'h0,        32'h0,        1, 5'd12, 32'h0000_0403, 5'd12, 32'h0040_0401,32'h0040_0401,32'h8000_0400,32'hBFC0_0100,1);
    add("exl_masks",        0, 0, 1, 1, 5'h0, 0, 32'h0,        32'h0,        0, 5'd0,  32'h0,        5'd12, 32'h0040_0403,32'h0040_0403,32'h8000_0400,32'hBFC0_0100,0);
    add("mtc0_vs_exc",      0, 0, 1, 0, 5'h5, 0, 32'h0000_1000,32'h2222_0000,1, 5'd12, 32'h0,        5'd12, 32'h0040_0401,32'h0040_0401,32'h8000_0000,32'hBFC0_0100,0);
    add("exc_won",          0, 0, 0, 0, 5'h0, 0, 32'h0,        32'h0,        0, 5'd0,  32'h0,        5'd8,  32'h2222_0000,32'h0040_0002,32'h0000_0014,32'h0000_1000,0);
    add("mtc0_cause",       0, 0, 0, 0, 5'h0, 0, 32'h0,        32'h0,        1, 5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0014,32'h0040_0002,32'h0000_0014,32'h0000_1000,0);
    add("mtc0_badvaddr",    0, 0, 0, 0, 5'h0, 0, 32'h0,        32'h0,        1, 5'd8,  32'h0000_1234, 5'd13, 32'h0000_0314,32'h0040_0002,32'h0000_0314,32'h0000_1000,0);
    add("badvaddr_ro",      0, 0, 0, 0, 5'h0, 0, 32'h0,        32'h0,        1, 5'd12, 32'h0000_0301, 5'd8,  32'h2222_0000,32'h0040_0002,32'h0000_0314,32'h0000_1000,0);
    add("sw_int_unmapped",  0, 0, 0, 0, 5'h0, 0, 32'h0,        32'h0,        1, 5'd14, 32'hA000_0000, 5'd20, 32'h0,        32'h0040_0301,32'h0000_0314,32'h0000_1000,1);
    add("mtc0_epc",         0, 0, 0, 0, 5'h0, 0, 32'h0,        32'h0,        1, 5'd20, 32'hFFFF_FFFF, 5'd14, 32'hA000_0000,32'h0040_0301,32'h0000_0314,32'hA000_0000,1);
    add("exc_epc_wrap",     0, 0, 1, 0, 5'h0, 1, 32'h0000_0002,32'h9999,     1, 5'd14, 32'h5555_5555, 5'd11, 32'h0,        32'h0040_0301,32'h0000_0314,32'hA000_0000,1);
    add("epc_wrapped",      0, 0, 0, 0, 5'h0, 0, 32'h0,        32'h0,        0, 5'd0,  32'h0,        5'd8,  32'h2222_0000,32'h0040_0303,32'h8000_0300,32'hFFFF_FFFE,0);
    add("rst_mid_exc",      1, 0, 1, 0, 5'h4, 1, 32'h0000_0040,32'h9999,     1, 5'd14, 32'h1,        5'd14, 32'hFFFF_FFFE,32'h0040_0303,32'h8000_0300,32'hFFFF_FFFE,0);
    add("after_rst",        0, 0, 0, 0, 5'h0, 0, 32'h0,        32'h0,        0, 5'd0,  32'h0,        5'd8,  32'h0,        32'h0040_0000,32'h0,        32'h0,        0);

    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      hw_v         = vecs[i].hw;
      rst          = vecs[i].rst;
      hw_int       = hw_v[HWN-1:0];
      exc_valid    = vecs[i].ev;
      exc_eret     = vecs[i].er;
      exc_code     = vecs[i].code;
      exc_in_ds    = vecs[i].ds;
      exc_pc       = vecs[i].pc;
      exc_badvaddr = vecs[i].bva;
      mtc0_en      = vecs[i].men;
      mtc0_addr    = vecs[i].maddr;
      mtc0_data    = vecs[i].mdata;
      mfc0_addr    = vecs[i].raddr;
      #1;
      $display("[TB] vec %0d %s: mfc0=%h status=%h cause=%h epc=%h int_req=%0d",
               i, vecs[i].name, mfc0_data, status, cause, epc, int_req);
      check({vecs[i].name, ".mfc0"},   mfc0_data, vecs[i].e_mfc0);
      check({vecs[i].name, ".status"}, status,    vecs[i].e_status);
      check({vecs[i].name, ".cause"},  cause,     vecs[i].e_cause);
      check({vecs[i].name, ".epc"},    epc,       vecs[i].e_epc);
      check({vecs[i].name, ".int"},    {31'b0, int_req}, {31'b0, vecs[i].e_int});
      @(negedge clk);
    end

    // Count divider, wrap and write-versus-tick priority.
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mfc0_addr = 5'd9;
    #1 check("count_at_release", mfc0_data, 32'd0);
    @(negedge clk);
    #1 check("count_1_cycle", mfc0_data, 32'd0);
    @(negedge clk);
    #1 check("count_first_inc", mfc0_data, 32'd1);
    for (int k = 0; k < 8; k++) @(negedge clk);
    #1 check("count_10_cycles", mfc0_data, 32'd5);
    $display("[TB] count after 10 cycles = %h", mfc0_data);
    mtc0(5'd9, 32'hFFFF_FFFF);
    #1 check("count_written", mfc0_data, 32'hFFFF_FFFF);
    @(negedge clk);
    #1 check("count_wrap", mfc0_data, 32'd0);
    @(negedge clk);
    #1 check("count_wrap_2cyc", mfc0_data, 32'd0);
    mtc0(5'd9, 32'h0000_0100);
    #1 check("count_write_vs_tick", mfc0_data, 32'h0000_0100);
    @(negedge clk);
    @(negedge clk);
    #1 check("count_after_collision", mfc0_data, 32'h0000_0101);
    $display("[TB] count write/tick sequence done, count = %h", mfc0_data);

`ifdef CP0_TIMER_INT_EN
    // Timer interrupt: Compare=10, IM7 and IE enabled.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mtc0(5'd11, 32'd10);
    mtc0(5'd12, 32'h0000_8001);
    mfc0_addr = 5'd11;
    #1 check("compare_readback", mfc0_data, 32'd10);
    check("ti_clear_start", {31'b0, cause[30]}, 32'd0);
    mfc0_addr = 5'd9;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      #1;
      if (int_req) seen = 1'b1;
      else @(negedge clk);
    end
    check("timer_int_seen", {31'b0, seen}, 32'd1);
    check("timer_count_at_int", mfc0_data, 32'd10);
    check("timer_ti", {31'b0, cause[30]}, 32'd1);
    check("timer_ip7", {31'b0, cause[15]}, 32'd1);
    $display("[TB] timer int at count=%h cause=%h", mfc0_data, cause);
    @(negedge clk);
    mtc0(5'd11, 32'h0000_1000);
    #1 check("ti_cleared", {31'b0, cause[30]}, 32'd0);
    check("timer_int_cleared", {31'b0, int_req}, 32'd0);
    $display("[TB] compare rewritten, cause=%h int_req=%0d", cause, int_req);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
